// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Tracks in-flight writers from EX through the last forwarding stage. From
//   that shadow state it produces per-operand bypass selects for the
//   instruction in EX and a load-use / long-latency stall for the instruction
//   in ID. It also keeps a saturating count of stall cycles.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   id_valid     ID holds a real instruction
//   id_rs        ID source indices, operand s at [s*AW +: AW]
//   id_rd        ID destination index
//   id_we        ID instruction writes rd
//   id_lat       stage boundaries until the ID result can be forwarded
//   pipe_hold    freezes all state
//   flush        kills the ID instruction
//   hz_stall     hold PC/IF/ID and inject a bubble into EX (combinational)
//   ex_fwd_sel   per EX operand: 0 = regfile, k = result after boundary k (combinational)
//   stall_cnt    saturating count of cycles lost to hz_stall
module hazard_fwd_unit #(
  parameter int unsigned AW    = 5,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned N_FWD = 2,
  parameter int unsigned LW    = 2,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned SW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_rs,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_we,
  input  logic [LW-1:0]        id_lat,
  input  logic                 pipe_hold,
  input  logic                 flush,
  output logic                 hz_stall,
  output logic [NSRC*SW-1:0]   ex_fwd_sel,
  output logic [CNT_W-1:0]     stall_cnt
);

  // Entry 0 is the instruction in EX, entry k is k boundaries past EX.
  localparam int unsigned NE = N_FWD + 1;

  logic [NE-1:0]   e_v;
  logic [NE-1:0]   e_we;
  logic [AW-1:0]   e_rd  [NE];
  logic [LW-1:0]   e_lat [NE];
  logic [AW-1:0]   ex_rs [NSRC];

  logic [LW-1:0]   lat_clamped;
  logic [NE-1:0]   ex_hit [NSRC];
  logic [NE-1:0]   id_hit [NSRC];
  logic [NSRC-1:0] src_stall;
  logic            issue;

  // Latency 0 behaves as 1; anything beyond the last forwarding stage is capped.
  always_comb begin
    lat_clamped = id_lat;
    if (id_lat == '0) begin
      lat_clamped = LW'(1);
    end else if (32'(id_lat) > N_FWD) begin
      lat_clamped = LW'(N_FWD);
    end
  end

  // Producer/consumer match matrices; x0 and non-writing entries never match.
  always_comb begin
    for (int s = 0; s < int'(NSRC); s++) begin
      for (int k = 0; k < int'(NE); k++) begin
        ex_hit[s][k] = e_v[k] & e_we[k] & (e_rd[k] != '0) & (e_rd[k] == ex_rs[s]);
        id_hit[s][k] = e_v[k] & e_we[k] & (e_rd[k] != '0) &
                       (e_rd[k] == id_rs[s*AW +: AW]);
      end
    end
  end

  // Bypass select: scan oldest to youngest so the youngest writer wins.
  always_comb begin
    ex_fwd_sel = '0;
    for (int s = 0; s < int'(NSRC); s++) begin
      for (int k = int'(N_FWD); k >= 1; k--) begin
        if (ex_hit[s][k]) begin
          ex_fwd_sel[s*SW +: SW] = SW'(k);
        end
      end
    end
  end

  // Stall: only the youngest matching writer decides whether its result is ready.
  always_comb begin
    src_stall = '0;
    for (int s = 0; s < int'(NSRC); s++) begin
      for (int p = int'(N_FWD) - 1; p >= 0; p--) begin
        if (id_hit[s][p]) begin
          src_stall[s] = (p + 1) < int'(e_lat[p]);
        end
      end
    end
    hz_stall = id_valid & ~flush & (|src_stall);
  end

  assign issue = id_valid & ~hz_stall & ~flush;

  // Shadow pipeline, EX operand indices and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_v       <= '0;
      e_we      <= '0;
      for (int k = 0; k < int'(NE); k++) begin
        e_rd[k]  <= '0;
        e_lat[k] <= '0;
      end
      for (int s = 0; s < int'(NSRC); s++) begin
        ex_rs[s] <= '0;
      end
      stall_cnt <= '0;
    end else if (!pipe_hold) begin
      for (int k = 1; k < int'(NE); k++) begin
        e_v[k]   <= e_v[k-1];
        e_we[k]  <= e_we[k-1];
        e_rd[k]  <= e_rd[k-1];
        e_lat[k] <= e_lat[k-1];
      end
      e_v[0]   <= issue;
      e_we[0]  <= issue & id_we;
      e_rd[0]  <= issue ? id_rd : '0;
      e_lat[0] <= issue ? lat_clamped : '0;
      for (int s = 0; s < int'(NSRC); s++) begin
        ex_rs[s] <= issue ? id_rs[s*AW +: AW] : '0;
      end
      if (hz_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Testbench for hazard_fwd_unit: directed vector table, hold/flush/reset
// sequences, randomized traffic against an age-based reference model, and
// counter saturation (counter narrowed so saturation is reachable quickly).
module tb_hazard_fwd_unit;

  localparam int AW    = 5;
  localparam int NSRC  = 2;
  localparam int N_FWD = 2;
  localparam int LW    = 2;
  localparam int CW    = 6;
  localparam int SW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                id_valid;
  logic [NSRC*AW-1:0]  id_rs;
  logic [AW-1:0]       id_rd;
  logic                id_we;
  logic [LW-1:0]       id_lat;
  logic                pipe_hold;
  logic                flush;
  logic                hz_stall;
  logic [NSRC*SW-1:0]  ex_fwd_sel;
  logic [CW-1:0]       stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.AW(AW), .NSRC(NSRC), .N_FWD(N_FWD), .LW(LW), .CNT_W(CW), .SW(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rd      (id_rd),
    .id_we      (id_we),
    .id_lat     (id_lat),
    .pipe_hold  (pipe_hold),
    .flush      (flush),
    .hz_stall   (hz_stall),
    .ex_fwd_sel (ex_fwd_sel),
    .stall_cnt  (stall_cnt)
  );

  // Reference model: a history of issued writers stamped with the advance
  // count at which they entered EX; age = advances since then.
  typedef struct {
    logic [AW-1:0] rd;
    logic          we;
    int            lat;
    int            t;
  } wr_t;

  wr_t           hist[$];
  int            adv;
  logic [AW-1:0] m_exrs [NSRC];
  int            m_cnt;
  logic          m_stall;
  int            m_sel [NSRC];

  typedef struct {
    bit v; int rs1; int rs2; int rd; bit we; int lat; bit hold; bit fl;
    bit stall; int sel0; int sel1; int cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    adv = 0;
    m_cnt = 0;
    for (int s = 0; s < NSRC; s++) m_exrs[s] = '0;
  endtask

  // Age of the youngest writer of r whose age lies in [lo,hi]; -1 if none.
  function automatic int youngest(input logic [AW-1:0] r, input int lo, input int hi,
                                  output int lat);
    int best_t;
    best_t = -1;
    lat = 0;
    if (r == '0) return -1;
    foreach (hist[i]) begin
      int age;
      age = adv - hist[i].t;
      if (hist[i].we && hist[i].rd == r && age >= lo && age <= hi && hist[i].t > best_t) begin
        best_t = hist[i].t;
        lat = hist[i].lat;
      end
    end
    return (best_t < 0) ? -1 : adv - best_t;
  endfunction

  task automatic model_eval();
    int a;
    int l;
    m_stall = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      logic [AW-1:0] r;
      r = id_rs[s*AW +: AW];
      a = youngest(r, 0, N_FWD - 1, l);
      if (a >= 0 && a + 1 < l) m_stall = 1'b1;
      a = youngest(m_exrs[s], 1, N_FWD, l);
      m_sel[s] = (a < 0) ? 0 : a;
    end
    m_stall = m_stall & id_valid & ~flush;
  endtask

  task automatic model_update();
    int l;
    if (!pipe_hold) begin
      adv++;
      if (id_valid && !m_stall && !flush) begin
        l = (id_lat == 0) ? 1 : ((int'(id_lat) > N_FWD) ? N_FWD : int'(id_lat));
        hist.push_back('{rd: id_rd, we: id_we, lat: l, t: adv});
        for (int s = 0; s < NSRC; s++) m_exrs[s] = id_rs[s*AW +: AW];
      end else begin
        for (int s = 0; s < NSRC; s++) m_exrs[s] = '0;
      end
      if (m_stall && m_cnt < CMAX) m_cnt++;
      while (hist.size() > 0 && adv - hist[0].t > N_FWD) void'(hist.pop_front());
    end
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input int rd, input bit we,
                       input int lat, input bit hold, input bit fl);
    id_valid  = v;
    id_rs     = {AW'(rs2), AW'(rs1)};
    id_rd     = AW'(rd);
    id_we     = we;
    id_lat    = LW'(lat);
    pipe_hold = hold;
    flush     = fl;
  endtask

  // Called at a falling edge with inputs applied; checks, then clocks once.
  task automatic step(input string tag);
    #1;
    model_eval();
    chk({tag, " model stall"}, 32'(hz_stall), 32'(m_stall));
    chk({tag, " model sel0"}, 32'(ex_fwd_sel[1:0]), 32'(m_sel[0]));
    chk({tag, " model sel1"}, 32'(ex_fwd_sel[3:2]), 32'(m_sel[1]));
    chk({tag, " model cnt"}, 32'(stall_cnt), 32'(m_cnt));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic add(input bit v, input int rs1, input int rs2, input int rd, input bit we,
                     input int lat, input bit hold, input bit fl,
                     input bit stall, input int sel0, input int sel1, input int cnt);
    tbl.push_back('{v, rs1, rs2, rd, we, lat, hold, fl, stall, sel0, sel1, cnt});
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset stall", 32'(hz_stall), 32'd0);
    chk("reset sel", 32'(ex_fwd_sel), 32'd0);
    chk("reset cnt", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;

    //   v rs1 rs2 rd we lat hold fl | stall sel0 sel1 cnt
    // ALU chain
    add(1, 0, 0,  5, 1, 1, 0, 0,  0, 0, 0, 0);
    add(1, 5, 0,  6, 1, 1, 0, 0,  0, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 0);
    // load-use
    add(1, 1, 0,  7, 1, 2, 0, 0,  0, 0, 0, 0);
    add(1, 0, 7,  8, 1, 1, 0, 0,  1, 0, 0, 0);
    add(1, 0, 7,  8, 1, 1, 0, 0,  0, 0, 0, 1);
    add(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 2, 1);
    // double writer
    add(1, 0, 0,  3, 1, 1, 0, 0,  0, 0, 0, 1);
    add(1, 0, 0,  3, 1, 1, 0, 0,  0, 0, 0, 1);
    add(1, 3, 0, 10, 1, 1, 0, 0,  0, 0, 0, 1);
    add(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 1);
    // load then ALU to the same register: younger ALU wins, no stall
    add(1, 0, 0,  3, 1, 2, 0, 0,  0, 0, 0, 1);
    add(1, 0, 0,  3, 1, 1, 0, 0,  0, 0, 0, 1);
    add(1, 3, 3, 11, 1, 1, 0, 0,  0, 0, 0, 1);
    add(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 1, 1);
    // x0 destination and we=0 producers
    add(1, 0, 0,  0, 1, 2, 0, 0,  0, 0, 0, 1);
    add(1, 0, 0,  9, 0, 2, 0, 0,  0, 0, 0, 1);
    add(1, 0, 9, 12, 1, 1, 0, 0,  0, 0, 0, 1);
    add(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 1);
    // latency clamping: 3 -> 2, 0 -> 1
    add(1, 0, 0, 13, 1, 3, 0, 0,  0, 0, 0, 1);
    add(1, 13, 0, 14, 1, 0, 0, 0, 1, 0, 0, 1);
    add(1, 13, 0, 14, 1, 0, 0, 0, 0, 0, 0, 2);
    add(1, 14, 0, 15, 1, 1, 0, 0, 0, 2, 0, 2);
    add(0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 2);
    // hold for 3 cycles during a load-use stall
    add(1, 0, 0,  7, 1, 2, 0, 0,  0, 0, 0, 2);
    add(1, 0, 7,  8, 1, 1, 1, 0,  1, 0, 0, 2);
    add(1, 0, 7,  8, 1, 1, 1, 0,  1, 0, 0, 2);
    add(1, 0, 7,  8, 1, 1, 1, 0,  1, 0, 0, 2);
    add(1, 0, 7,  8, 1, 1, 0, 0,  1, 0, 0, 2);
    add(1, 0, 7,  8, 1, 1, 0, 0,  0, 0, 0, 3);
    add(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 2, 3);
    // flush wins over a would-be stall
    add(1, 0, 0,  7, 1, 2, 0, 0,  0, 0, 0, 3);
    add(1, 0, 7,  8, 1, 1, 0, 1,  0, 0, 0, 3);
    add(1, 0, 7,  8, 1, 1, 0, 0,  0, 0, 0, 3);
    add(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 2, 3);

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].we, tbl[i].lat,
            tbl[i].hold, tbl[i].fl);
      #1;
      chk({tag, " stall"}, 32'(hz_stall), 32'(tbl[i].stall));
      chk({tag, " sel0"}, 32'(ex_fwd_sel[1:0]), 32'(tbl[i].sel0));
      chk({tag, " sel1"}, 32'(ex_fwd_sel[3:2]), 32'(tbl[i].sel1));
      chk({tag, " cnt"}, 32'(stall_cnt), 32'(tbl[i].cnt));
      step(tag);
    end

    // Randomized traffic over a small register set to provoke dependencies.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(99) < 80, $urandom_range(7), $urandom_range(7), $urandom_range(7),
            $urandom_range(99) < 85, $urandom_range(3), $urandom_range(99) < 10,
            $urandom_range(99) < 10);
      step("rand");
    end

    // Asynchronous reset in the middle of a stall.
    drive(1, 0, 0, 7, 1, 2, 0, 0);
    step("pre-rst load");
    drive(1, 0, 7, 8, 1, 1, 0, 0);
    #1;
    chk("pre-rst stall", 32'(hz_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst stall", 32'(hz_stall), 32'd0);
    chk("mid-rst sel", 32'(ex_fwd_sel), 32'd0);
    chk("mid-rst cnt", 32'(stall_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back dependent loads: one stall every two cycles until saturation.
    drive(1, 7, 0, 7, 1, 2, 0, 0);
    for (int i = 0; i < 2 * CMAX + 20; i++) step("sat");
    chk("sat cnt", 32'(stall_cnt), 32'(CMAX));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
